button_event_decoder: RTL

- Consumer side of the debounced button path. Takes one clean, already-synchronized button level from the debouncer and turns it into one-cycle event pulses for the clock-setting logic.
- Events: press, short press, long press, auto-repeat, step and release, plus a held level.
- Timing runs on an external tick strobe, so long-press and repeat periods come from the shared prescaler rather than raw 10 MHz cycles.

---
 rtl/button_event_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a clean button level into registered
// one-cycle press/short/long/repeat/step/release pulses plus a held level.
module button_event_decoder #(
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_tick,
  output logic o_held,
  output logic o_press,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_step,
  output logic o_release
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;
  logic             step_q, step_d;
  logic             rel_q, rel_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      step_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      step_q  <= step_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    step_d  = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_level) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          step_d  = 1'b1;
        end
      end
      PRESSED: begin
        // Release beats a coincident tick.
        if (!i_level) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
          rel_d   = 1'b1;
        end else if (i_tick && cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else if (i_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (!i_level) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else if (i_tick && cnt_q == REP_LAST) begin
          cnt_d  = '0;
          rep_d  = REPEAT_EN;
          step_d = REPEAT_EN;
        end else if (i_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  assign o_held    = held_q;
  assign o_press   = press_q;
  assign o_short   = short_q;
  assign o_long    = long_q;
  assign o_repeat  = rep_q;
  assign o_step    = step_q;
  assign o_release = rel_q;

endmodule
